// File: rtl/cci_mpf_svc_vtp_pt_fim_port.sv
// VTP page-table-walker FIM port: serial page-table reads on c0, throttled
// message writes on c1, with responses filtered by a fixed metadata tag.
module cci_mpf_svc_vtp_pt_fim_port #(
  parameter logic [15:0] MDATA_TAG  = 16'hA5C0,
  parameter int unsigned MAX_WRITES = 4
) (
  input  logic         clk,
  input  logic         reset_n,

  input  logic         readEn,
  input  logic [41:0]  readAddr,
  output logic         readRdy,
  output logic         readDataEn,
  output logic [511:0] readData,

  input  logic         writeEn,
  input  logic [41:0]  writeAddr,
  input  logic [63:0]  writeData,
  output logic         writeRdy,

  output logic         c0TxValid,
  output logic [41:0]  c0TxAddr,
  output logic [15:0]  c0TxMdata,
  input  logic         c0TxAlmFull,
  input  logic         c0RxValid,
  input  logic [15:0]  c0RxMdata,
  input  logic [511:0] c0RxData,

  output logic         c1TxValid,
  output logic [41:0]  c1TxAddr,
  output logic [511:0] c1TxData,
  output logic [15:0]  c1TxMdata,
  input  logic         c1TxAlmFull,
  input  logic         c1RxValid,
  input  logic [15:0]  c1RxMdata,

  output logic         wrIdle,
  output logic         errUnexpectedRsp
);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } rdState_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WRITES);

  rdState_t   state, stateNext;
  logic       c0Match, c1Match;
  logic       readAccept, rspTake, unexpC0;
  logic       wrAccept, ackOk, unexpC1;
  logic [3:0] wrCnt;

  assign c0Match   = c0RxValid && (c0RxMdata == MDATA_TAG);
  assign c1Match   = c1RxValid && (c1RxMdata == MDATA_TAG);
  assign c0TxMdata = MDATA_TAG;
  assign c1TxMdata = MDATA_TAG;

  // Ready is forced low while reset_n is held, independent of almost-full.
  assign readRdy  = reset_n && (state == IDLE) && !c0TxAlmFull;
  assign writeRdy = reset_n && !c1TxAlmFull && (wrCnt < MAX_W);
  assign wrIdle   = (wrCnt == '0);

  assign wrAccept = writeEn && writeRdy;
  assign ackOk    = c1Match && (wrCnt != '0);
  assign unexpC1  = c1Match && (wrCnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    readAccept = 1'b0;
    rspTake    = 1'b0;
    unexpC0    = 1'b0;
    case (state)
      IDLE: begin
        if (c0Match) unexpC0 = 1'b1;
        if (readEn && readRdy) begin
          readAccept = 1'b1;
          stateNext  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (c0Match) begin
          rspTake   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0TxValid  <= 1'b0;
      c0TxAddr   <= '0;
      readDataEn <= 1'b0;
      readData   <= '0;
    end else begin
      c0TxValid  <= readAccept;
      readDataEn <= rspTake;
      if (readAccept) c0TxAddr <= readAddr;
      if (rspTake)    readData <= c0RxData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1TxValid <= 1'b0;
      c1TxAddr  <= '0;
      c1TxData  <= '0;
      wrCnt     <= '0;
    end else begin
      c1TxValid <= wrAccept;
      if (wrAccept) begin
        c1TxAddr <= writeAddr;
        c1TxData <= {448'b0, writeData};
      end
      case ({wrAccept, ackOk})
        2'b10:   wrCnt <= wrCnt + 4'd1;
        2'b01:   wrCnt <= wrCnt - 4'd1;
        default: wrCnt <= wrCnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                errUnexpectedRsp <= 1'b0;
    else if (unexpC0 || unexpC1) errUnexpectedRsp <= 1'b1;
  end

endmodule

// File: tb/tb_cci_mpf_svc_vtp_pt_fim_port.sv
// Directed bench for the VTP FIM port: vector table plus hand-written
// sequences for data paths, same-cycle response and mid-read reset.
module tb_cci_mpf_svc_vtp_pt_fim_port;

  localparam logic [15:0] T = 16'hA5C0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         readEn, readRdy, readDataEn;
  logic [41:0]  readAddr;
  logic [511:0] readData;
  logic         writeEn, writeRdy;
  logic [41:0]  writeAddr;
  logic [63:0]  writeData;
  logic         c0TxValid, c0TxAlmFull, c0RxValid;
  logic [41:0]  c0TxAddr;
  logic [15:0]  c0TxMdata, c0RxMdata;
  logic [511:0] c0RxData;
  logic         c1TxValid, c1TxAlmFull, c1RxValid;
  logic [41:0]  c1TxAddr;
  logic [511:0] c1TxData;
  logic [15:0]  c1TxMdata, c1RxMdata;
  logic         wrIdle, errUnexpectedRsp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cci_mpf_svc_vtp_pt_fim_port #(.MDATA_TAG(16'hA5C0), .MAX_WRITES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .readEn(readEn), .readAddr(readAddr), .readRdy(readRdy),
    .readDataEn(readDataEn), .readData(readData),
    .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .writeRdy(writeRdy),
    .c0TxValid(c0TxValid), .c0TxAddr(c0TxAddr), .c0TxMdata(c0TxMdata),
    .c0TxAlmFull(c0TxAlmFull), .c0RxValid(c0RxValid), .c0RxMdata(c0RxMdata),
    .c0RxData(c0RxData),
    .c1TxValid(c1TxValid), .c1TxAddr(c1TxAddr), .c1TxData(c1TxData),
    .c1TxMdata(c1TxMdata), .c1TxAlmFull(c1TxAlmFull), .c1RxValid(c1RxValid),
    .c1RxMdata(c1RxMdata),
    .wrIdle(wrIdle), .errUnexpectedRsp(errUnexpectedRsp)
  );

  typedef struct {
    bit          rEn;
    logic [41:0] rAddr;
    bit          c0AF;
    bit          c0Rv;
    logic [15:0] c0Md;
    bit          wEn;
    bit          c1AF;
    bit          c1Rv;
    logic [15:0] c1Md;
    bit          xRRdy;   // before the edge
    bit          xWRdy;   // before the edge
    bit          xC0V;    // after the edge
    bit          xC1V;
    bit          xRdEn;
    bit          xIdle;
    bit          xErr;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clearIn();
    readEn = 0; readAddr = '0; c0TxAlmFull = 0; c0RxValid = 0; c0RxMdata = '0;
    c0RxData = '0; writeEn = 0; writeAddr = '0; writeData = '0;
    c1TxAlmFull = 0; c1RxValid = 0; c1RxMdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] pat;
    clearIn();
    reset_n = 0;

    tbl[0]  = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 0, 16'h0,    1, 1, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 42'h123, 0, 0, 16'h0,    0, 0, 0, 16'h0,    1, 1, 1, 0, 0, 1, 0};
    tbl[2]  = '{0, 42'h0,   0, 1, 16'h0001, 0, 0, 0, 16'h0,    0, 1, 0, 0, 0, 1, 0};
    tbl[3]  = '{0, 42'h0,   0, 1, T,        0, 0, 0, 16'h0,    0, 1, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 0, 16'h0,    1, 1, 0, 0, 0, 1, 0};
    tbl[5]  = '{1, 42'h77,  1, 0, 16'h0,    0, 0, 0, 16'h0,    0, 1, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 42'h0,   0, 0, 16'h0,    1, 1, 0, 16'h0,    1, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 42'h0,   0, 0, 16'h0,    1, 0, 0, 16'h0,    1, 1, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 42'h0,   0, 0, 16'h0,    1, 0, 0, 16'h0,    1, 1, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 42'h0,   0, 0, 16'h0,    1, 0, 0, 16'h0,    1, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 42'h0,   0, 0, 16'h0,    1, 0, 0, 16'h0,    1, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 42'h0,   0, 0, 16'h0,    1, 0, 0, 16'h0,    1, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 1, T,        1, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 42'h0,   0, 0, 16'h0,    1, 0, 1, T,        1, 1, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 1, 16'h1234, 1, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 1, T,        1, 1, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 1, T,        1, 1, 0, 0, 0, 0, 0};
    tbl[17] = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 1, T,        1, 1, 0, 0, 0, 1, 0};
    tbl[18] = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 1, T,        1, 1, 0, 0, 0, 1, 1};
    tbl[19] = '{0, 42'h0,   0, 1, T,        0, 0, 0, 16'h0,    1, 1, 0, 0, 0, 1, 1};
    tbl[20] = '{0, 42'h0,   0, 0, 16'h0,    0, 0, 0, 16'h0,    1, 1, 0, 0, 0, 1, 1};

    // Reset values while reset_n is held low
    tick(); tick();
    chk("rst readRdy", 512'(readRdy), 512'(0));
    chk("rst writeRdy", 512'(writeRdy), 512'(0));
    chk("rst readDataEn", 512'(readDataEn), 512'(0));
    chk("rst readData", readData, '0);
    chk("rst c0TxValid", 512'(c0TxValid), 512'(0));
    chk("rst c1TxValid", 512'(c1TxValid), 512'(0));
    chk("rst c0TxMdata", 512'(c0TxMdata), 512'(T));
    chk("rst c1TxMdata", 512'(c1TxMdata), 512'(T));
    chk("rst wrIdle", 512'(wrIdle), 512'(1));
    chk("rst err", 512'(errUnexpectedRsp), 512'(0));
    reset_n = 1;
    tick();

    for (int i = 0; i < 21; i++) begin
      readEn = tbl[i].rEn; readAddr = tbl[i].rAddr; c0TxAlmFull = tbl[i].c0AF;
      c0RxValid = tbl[i].c0Rv; c0RxMdata = tbl[i].c0Md; writeEn = tbl[i].wEn;
      c1TxAlmFull = tbl[i].c1AF; c1RxValid = tbl[i].c1Rv; c1RxMdata = tbl[i].c1Md;
      #1;
      chk($sformatf("v%0d readRdy", i), 512'(readRdy), 512'(tbl[i].xRRdy));
      chk($sformatf("v%0d writeRdy", i), 512'(writeRdy), 512'(tbl[i].xWRdy));
      tick();
      chk($sformatf("v%0d c0TxValid", i), 512'(c0TxValid), 512'(tbl[i].xC0V));
      chk($sformatf("v%0d c1TxValid", i), 512'(c1TxValid), 512'(tbl[i].xC1V));
      chk($sformatf("v%0d readDataEn", i), 512'(readDataEn), 512'(tbl[i].xRdEn));
      chk($sformatf("v%0d wrIdle", i), 512'(wrIdle), 512'(tbl[i].xIdle));
      chk($sformatf("v%0d err", i), 512'(errUnexpectedRsp), 512'(tbl[i].xErr));
      if (tbl[i].xC0V) begin
        chk($sformatf("v%0d c0TxAddr", i), 512'(c0TxAddr), 512'(tbl[i].rAddr));
        chk($sformatf("v%0d c0TxMdata", i), 512'(c0TxMdata), 512'(T));
      end
      clearIn();
    end

    // Response arriving in the same cycle as c0TxValid; data returned intact
    pat = {16{32'hDEADBEEF}};
    pat[15:0] = 16'h1357;
    readEn = 1; readAddr = 42'h3FF_FFFF_FFFF;
    tick();
    clearIn();
    chk("same c0TxValid", 512'(c0TxValid), 512'(1));
    chk("same c0TxAddr", 512'(c0TxAddr), 512'(42'h3FF_FFFF_FFFF));
    c0RxValid = 1; c0RxMdata = T; c0RxData = pat;
    tick();
    clearIn();
    chk("same readDataEn", 512'(readDataEn), 512'(1));
    chk("same readData", readData, pat);
    chk("same readRdy", 512'(readRdy), 512'(1));
    tick();
    chk("same readDataEn pulse", 512'(readDataEn), 512'(0));
    chk("same c0TxValid pulse", 512'(c0TxValid), 512'(0));

    // Write data placement and address
    writeEn = 1; writeAddr = 42'h155; writeData = 64'h0123456789ABCDEF;
    tick();
    clearIn();
    chk("wr c1TxValid", 512'(c1TxValid), 512'(1));
    chk("wr c1TxAddr", 512'(c1TxAddr), 512'(42'h155));
    chk("wr c1TxData", c1TxData, {448'b0, 64'h0123456789ABCDEF});
    chk("wr c1TxMdata", 512'(c1TxMdata), 512'(T));
    chk("wr wrIdle", 512'(wrIdle), 512'(0));

    // Asynchronous reset while waiting on a read
    readEn = 1; readAddr = 42'h2AA;
    tick();
    clearIn();
    chk("rw readRdy busy", 512'(readRdy), 512'(0));
    reset_n = 0;
    #1;
    chk("rw readRdy", 512'(readRdy), 512'(0));
    chk("rw c0TxValid", 512'(c0TxValid), 512'(0));
    chk("rw c0TxAddr", 512'(c0TxAddr), 512'(0));
    chk("rw c1TxData", c1TxData, '0);
    chk("rw readData", readData, '0);
    chk("rw wrIdle", 512'(wrIdle), 512'(1));
    chk("rw err", 512'(errUnexpectedRsp), 512'(0));
    tick();
    reset_n = 1;
    #1;
    chk("rw readRdy idle", 512'(readRdy), 512'(1));
    chk("rw writeRdy", 512'(writeRdy), 512'(1));
    c0RxValid = 1; c0RxMdata = T; c0RxData = pat;
    tick();
    clearIn();
    chk("rw late readDataEn", 512'(readDataEn), 512'(0));
    chk("rw late err", 512'(errUnexpectedRsp), 512'(1));
    chk("rw late readData", readData, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cci_mpf_svc_vtp_pt_fim_port.md
# cci_mpf_svc_vtp_pt_fim_port

Memory-side endpoint of the VTP page-table-walker FIM interface: accepts page-table reads and 64-bit message writes from the walker and issues them as line requests on a dedicated CCI-style read channel (c0) and write channel (c1). It filters c0/c1 responses by a fixed metadata tag, so it can share channels with other MPF traffic. It returns read data to the walker and tracks outstanding writes. It sits between the VTP page table walker and the MPF channel arbiter.

## Interface
- MDATA_TAG, 16'hA5C0, metadata value stamped on every request; responses match on all 16 bits.
- MAX_WRITES, 4, maximum outstanding unacknowledged writes (1..15).
- clk  in  1  clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- readEn  in  1  walker read request; accepted only when readRdy=1.
- readAddr  in  42  line address to read.
- readRdy  out  1  port can accept a read this cycle.
- readDataEn  out  1  one-cycle pulse, readData valid.
- readData  out  512  returned line.
- writeEn  in  1  walker write request; accepted only when writeRdy=1.
- writeAddr  in  42  line address to write.
- writeData  in  64  message, placed in line bits [63:0].
- writeRdy  out  1  port can accept a write this cycle.
- c0TxValid  out  1  read request valid (one cycle per request).
- c0TxAddr  out  42  read line address.
- c0TxMdata  out  16  always MDATA_TAG.
- c0TxAlmFull  in  1  read channel backpressure.
- c0RxValid  in  1  read response valid.
- c0RxMdata  in  16  read response metadata.
- c0RxData  in  512  read response line.
- c1TxValid  out  1  write request valid.
- c1TxAddr  out  42  write line address.
- c1TxData  out  512  {448'b0, writeData}.
- c1TxMdata  out  16  always MDATA_TAG.
- c1TxAlmFull  in  1  write channel backpressure.
- c1RxValid  in  1  write ack valid.
- c1RxMdata  in  16  write ack metadata.
- wrIdle  out  1  no writes outstanding.
- errUnexpectedRsp  out  1  sticky error flag.

## Operation
- Read FSM, states IDLE and RD_WAIT; reset -> IDLE.
- IDLE: readRdy = !c0TxAlmFull. When readEn && readRdy: register readAddr to c0TxAddr, assert c0TxValid next cycle, go to RD_WAIT.
- RD_WAIT: readRdy=0. When c0RxValid && c0RxMdata==MDATA_TAG: register c0RxData to readData, pulse readDataEn next cycle, return to IDLE.
- Only one read is outstanding at a time; walker reads are serial.
- In IDLE, a matching c0 response sets errUnexpectedRsp and is discarded. The flag clears only on reset.
- Responses with non-matching mdata are ignored on both channels.
- Write counter wrCnt is 4 bits, reset to 0.
- writeRdy = !c1TxAlmFull && (wrCnt < MAX_WRITES).
- An accepted write increments wrCnt and drives c1TxValid/Addr/Data next cycle.
- A matching c1RxValid decrements wrCnt.
- A simultaneous accept and ack leaves wrCnt unchanged.
- A matching ack while wrCnt==0 sets errUnexpectedRsp; wrCnt stays 0 (no underflow).
- wrIdle = (wrCnt==0).
- Reads and writes are independent and may be accepted in the same cycle.

## Timing
- Reset values: readRdy=0 while reset_n low, then follows the rules above. readDataEn=0, readData=0, writeRdy=0 in reset. c0TxValid=0, c1TxValid=0, all Tx addr/data=0, Tx mdata=MDATA_TAG. wrIdle=1, errUnexpectedRsp=0.
- Request latency: readEn/writeEn accepted at cycle t -> c0TxValid/c1TxValid high at t+1 for exactly one cycle.
- Read response latency: matching c0RxValid at cycle r -> readDataEn at r+1. FSM is in IDLE at r+1, so readRdy can be 1 at r+1.
- A matching response arriving in the same cycle as c0TxValid is accepted.
- readRdy/writeRdy are combinational from state and almost-full only; they never depend on readEn/writeEn.
- Almost-full asserted after acceptance does not cancel the registered Tx.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Responses for requests in flight before reset are treated as unexpected if they arrive in IDLE after reset.

## Test plan
- Single read: readEn, readAddr=42'h123 -> c0TxValid one cycle later with addr 42'h123, mdata 16'hA5C0. Response with data pattern 512'hDEAD... -> readDataEn one cycle later with the same data; readRdy back to 1.
- Foreign response: in RD_WAIT, c0Rx with mdata 16'h0001 -> ignored, no readDataEn. A following tagged response completes normally.
- Write throttle: 5 back-to-back writes, no acks -> 4 c1TxValid pulses, writeRdy=0 after the 4th. One ack -> writeRdy=1; wrIdle=1 only after 4 acks.
- Backpressure: c0TxAlmFull=1 -> readRdy=0, no c0TxValid. c1TxAlmFull=1 -> writeRdy=0. Deassert -> requests proceed.
- Errors: tagged c0 response in IDLE and tagged c1 ack with wrCnt=0 -> errUnexpectedRsp=1 and stays 1 until reset; wrCnt stays 0.
- Write data and simultaneous traffic: writeData=64'h0123456789ABCDEF -> c1TxData low 64 bits match, bits [511:64]=0. Accept and ack in the same cycle -> wrCnt unchanged. Reset asserted in RD_WAIT -> IDLE, outputs at reset values.
